// File: rtl/sa_sequencer_if.sv
// Row-beat bus between the tile feeder and the systolic array input skew logic.
interface sa_sequencer_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8
);
  localparam int unsigned W = N * DW;

  logic         i_start;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_A;
  logic [W-1:0] i_B;
  logic [W-1:0] o_A;
  logic [W-1:0] o_B;
  logic         o_push;
  logic         o_pe_clr;
  logic         o_busy;
  logic         o_done;

  // Feeder / testbench side
  modport master (
    output i_start, i_valid, i_A, i_B,
    input  o_ready, o_A, o_B, o_push, o_pe_clr, o_busy, o_done
  );

  // Sequencer side
  modport slave (
    input  i_start, i_valid, i_A, i_B,
    output o_ready, o_A, o_B, o_push, o_pe_clr, o_busy, o_done
  );
endinterface

// File: rtl/sa_sequencer.sv
// Tile sequencer for an N x N systolic array: clears PEs, feeds N row/column
// beats, waits for the array to drain, then pulses done.
module sa_sequencer #(
  parameter int unsigned N         = 3,
  parameter int unsigned DW        = 8,
  parameter int unsigned DRAIN_CYC = 3 * N - 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sa_sequencer_if.slave  sif
);
  localparam int unsigned W       = N * DW;
  localparam int unsigned CNT_MAX = (N > DRAIN_CYC) ? N : DRAIN_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          push_q, push_d;
  logic          pe_clr_q;
  logic          done_q;
  logic          accept;

  assign accept = (state_q == ST_FEED) && sif.i_valid;

  // Next state, shared beat/drain counter, and next beat payload
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push_d  = 1'b0;
    a_d     = '0;
    b_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (sif.i_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (accept) begin
          push_d = 1'b1;
          a_d    = sif.i_A;
          b_d    = sif.i_B;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; done is taken off the DONE state so it
  // lands DRAIN_CYC+1 cycles after the last push
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      push_q   <= 1'b0;
      pe_clr_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      push_q   <= push_d;
      pe_clr_q <= (state_d == ST_CLEAR);
      done_q   <= (state_q == ST_DONE);
    end
  end

  assign sif.o_A      = a_q;
  assign sif.o_B      = b_q;
  assign sif.o_push   = push_q;
  assign sif.o_pe_clr = pe_clr_q;
  assign sif.o_done   = done_q;
  assign sif.o_ready  = (state_q == ST_FEED);
  assign sif.o_busy   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sa_sequencer.sv
// Bench for sa_sequencer: a fixed nominal-tile table, hand-written corner
// sequences, and random traffic against a timestamp-based tile model, on
// an N=3 and an N=4 instance.
module tb_sa_sequencer;
  logic clk;
  logic rst_n;

  sa_sequencer_if #(.N(3), .DW(8)) if3 ();
  sa_sequencer_if #(.N(4), .DW(8)) if4 ();

  sa_sequencer #(.N(3), .DW(8)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .sif(if3.slave));
  sa_sequencer #(.N(4), .DW(8)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .sif(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int sel   = 0;  // 0: N=3 instance, 1: N=4 instance

  // Tile model: a tile is described by its clear cycle, beats taken so far
  // and the cycle of its last push; all timing is derived from those.
  bit          m_active;
  int          m_tclr, m_beats, m_tlast, m_n, m_drain;
  bit          p_push;
  logic [31:0] p_a, p_b;

  function automatic bit m_idle(int c);
    return !m_active || (m_beats == m_n && c > m_tlast + m_drain);
  endfunction

  function automatic bit m_feeding(int c);
    return m_active && c >= m_tclr + 1 && m_beats < m_n;
  endfunction

  function automatic logic [31:0] dmask();
    return (sel == 0) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic mdl_reset();
    m_active = 1'b0;
    m_beats  = 0;
    m_tclr   = 0;
    m_tlast  = 0;
    p_push   = 1'b0;
    p_a      = '0;
    p_b      = '0;
    m_n      = (sel == 0) ? 3 : 4;
    m_drain  = 3 * m_n - 2;
  endtask

  task automatic mdl_update(input bit st, input bit vl, input logic [31:0] a, input logic [31:0] b);
    bit f;
    f      = m_feeding(cyc);
    p_push = f && vl;
    p_a    = p_push ? a : 32'h0;
    p_b    = p_push ? b : 32'h0;
    if (p_push) begin
      m_beats++;
      if (m_beats == m_n) m_tlast = cyc + 1;
    end
    if (m_idle(cyc)) begin
      if (st) begin
        m_active = 1'b1;
        m_tclr   = cyc + 1;
        m_beats  = 0;
      end else begin
        m_active = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s sel=%0d cyc=%0d got=%h want=%h", name, sel, cyc, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input bit act, input bit exp);
    chk(name, {31'h0, act}, {31'h0, exp});
  endtask

  task automatic get_outs(output bit rdy, output bit busy, output bit clr, output bit push,
                          output bit done, output logic [31:0] a, output logic [31:0] b);
    if (sel == 0) begin
      rdy = if3.o_ready; busy = if3.o_busy; clr = if3.o_pe_clr; push = if3.o_push;
      done = if3.o_done; a = {8'h0, if3.o_A}; b = {8'h0, if3.o_B};
    end else begin
      rdy = if4.o_ready; busy = if4.o_busy; clr = if4.o_pe_clr; push = if4.o_push;
      done = if4.o_done; a = if4.o_A; b = if4.o_B;
    end
  endtask

  task automatic drive(input bit st, input bit vl, input logic [31:0] a, input logic [31:0] b);
    if3.i_start = (sel == 0) && st;
    if3.i_valid = (sel == 0) && vl;
    if3.i_A     = (sel == 0) ? a[23:0] : 24'h0;
    if3.i_B     = (sel == 0) ? b[23:0] : 24'h0;
    if4.i_start = (sel == 1) && st;
    if4.i_valid = (sel == 1) && vl;
    if4.i_A     = (sel == 1) ? a : 32'h0;
    if4.i_B     = (sel == 1) ? b : 32'h0;
  endtask

  // Compare the selected DUT against the model for this cycle, then apply inputs
  task automatic cycle(input bit st, input bit vl, input logic [31:0] a, input logic [31:0] b);
    bit rdy, busy, clr, push, done;
    logic [31:0] oa, ob, ma, mb;
    get_outs(rdy, busy, clr, push, done, oa, ob);
    chk_b("mdl_ready", rdy, m_feeding(cyc));
    chk_b("mdl_busy", busy, !m_idle(cyc));
    chk_b("mdl_pe_clr", clr, m_active && cyc == m_tclr);
    chk_b("mdl_push", push, p_push);
    chk("mdl_A", oa, p_a);
    chk("mdl_B", ob, p_b);
    chk_b("mdl_done", done, m_active && m_beats == m_n && cyc == m_tlast + m_drain + 1);
    ma = a & dmask();
    mb = b & dmask();
    drive(st, vl, ma, mb);
    mdl_update(st, vl, ma, mb);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    bit rdy, busy, clr, push, done;
    logic [31:0] oa, ob;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    get_outs(rdy, busy, clr, push, done, oa, ob);
    chk_b("rst_ready", rdy, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_pe_clr", clr, 1'b0);
    chk_b("rst_push", push, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk("rst_A", oa, 32'h0);
    chk("rst_B", ob, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    mdl_reset();
  endtask

  typedef struct {
    bit          st;
    bit          vl;
    logic [31:0] a;
    logic [31:0] b;
    bit          e_rdy;
    bit          e_busy;
    bit          e_clr;
    bit          e_push;
    logic [31:0] e_a;
    logic [31:0] e_b;
    bit          e_done;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] beat_a [3];
  logic [31:0] beat_b [3];

  initial begin
    bit rdy, busy, clr, push, done;
    logic [31:0] oa, ob;
    int last_push, done_cyc, n_done, n_push, d1, d2;

    beat_a = '{32'h111, 32'h333, 32'h555};
    beat_b = '{32'h222, 32'h444, 32'h666};
    for (int i = 0; i < 15; i++) begin
      tbl[i] = '{default: 0};
      tbl[i].e_busy = (i >= 1 && i <= 12);
    end
    tbl[0].st    = 1'b1;
    tbl[1].e_clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tbl[2 + k].vl     = 1'b1;
      tbl[2 + k].a      = beat_a[k];
      tbl[2 + k].b      = beat_b[k];
      tbl[2 + k].e_rdy  = 1'b1;
      tbl[3 + k].e_push = 1'b1;
      tbl[3 + k].e_a    = beat_a[k];
      tbl[3 + k].e_b    = beat_b[k];
    end
    tbl[13].e_done = 1'b1;

    rst_n = 1'b0;
    sel   = 0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mdl_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      get_outs(rdy, busy, clr, push, done, oa, ob);
      chk_b("reset_ready", rdy, 1'b0);
      chk_b("reset_busy", busy, 1'b0);
      chk_b("reset_push", push, 1'b0);
      chk_b("reset_done", done, 1'b0);
      chk_b("reset_pe_clr", clr, 1'b0);
      chk("reset_A", oa, 32'h0);
    end
    sel = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    mdl_reset();

    // Nominal tile from the fixed table
    for (int i = 0; i < 15; i++) begin
      get_outs(rdy, busy, clr, push, done, oa, ob);
      chk_b("tbl_ready", rdy, tbl[i].e_rdy);
      chk_b("tbl_busy", busy, tbl[i].e_busy);
      chk_b("tbl_pe_clr", clr, tbl[i].e_clr);
      chk_b("tbl_push", push, tbl[i].e_push);
      chk("tbl_A", oa, tbl[i].e_a);
      chk("tbl_B", ob, tbl[i].e_b);
      chk_b("tbl_done", done, tbl[i].e_done);
      cycle(tbl[i].st, tbl[i].vl, tbl[i].a, tbl[i].b);
    end

    // Reset after the second beat is accepted, then a clean full tile
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0A0B0C, 32'h0D0E0F);
    cycle(1'b0, 1'b1, 32'h102030, 32'h405060);
    do_reset();
    n_done = 0;
    n_push = 0;
    cycle(1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, $urandom, $urandom);
      get_outs(rdy, busy, clr, push, done, oa, ob);
      if (push) n_push++;
      if (done) n_done++;
    end
    chk("after_rst_pushes", 32'(n_push), 32'd3);
    chk("after_rst_dones", 32'(n_done), 32'd1);

    // Back-to-back tiles: second start lands on the done cycle
    do_reset();
    d1 = -1;
    d2 = -1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(i == 0 || i == 13, 1'b1, $urandom, $urandom);
      get_outs(rdy, busy, clr, push, done, oa, ob);
      if (done) begin
        n_done++;
        if (d1 < 0) d1 = i + 1;
        else if (d2 < 0) d2 = i + 1;
      end
    end
    chk("b2b_dones", 32'(n_done), 32'd2);
    chk("b2b_first_done", 32'(d1), 32'd13);
    chk("b2b_period", 32'(d2 - d1), 32'd13);

    // N=4 instance: done 11 cycles after the last push
    sel = 1;
    do_reset();
    last_push = -100;
    done_cyc  = -1;
    cycle(1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b1, $urandom, $urandom);
      get_outs(rdy, busy, clr, push, done, oa, ob);
      if (push) last_push = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    chk("n4_latency", 32'(done_cyc - last_push), 32'd11);

    // Random traffic on both instances, with occasional mid-tile resets
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 149) == 0) do_reset();
        else cycle($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sa_sequencer.md
SA_SEQUENCER -- requirements
Module: sa_sequencer

Interface
REQ-001 Parameter N, default 3, meaning systolic array dimension (rows of A, columns of B per tile).
REQ-002 Parameter DW, default 8, meaning element width; row bus width W = N*DW (24 at defaults).
REQ-003 Parameter DRAIN_CYC, default 3*N-2 (7), meaning cycles held after last beat until results settle.
REQ-004 i_clk  input  1  single clock; all logic rising-edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_start  input  1  one-cycle request to run one tile.
REQ-007 i_valid  input  1  row beat valid on i_A/i_B.
REQ-008 o_ready  output  1  sequencer accepts a beat this cycle.
REQ-009 i_A  input  W  packed row of A (element k at bits [k*DW +: DW]).
REQ-010 i_B  input  W  packed column of B, same packing.
REQ-011 o_A  output  W  registered row to input skew logic.
REQ-012 o_B  output  W  registered column to input skew logic.
REQ-013 o_push  output  1  registered; high when o_A/o_B carry an accepted beat.
REQ-014 o_pe_clr  output  1  one-cycle clear of PE accumulators.
REQ-015 o_busy  output  1  high in any state other than IDLE.
REQ-016 o_done  output  1  one-cycle pulse when tile results are valid.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-018 IDLE: o_ready=0; i_start=1 -> CLEAR next cycle; otherwise stay.
REQ-019 CLEAR: o_pe_clr=1 for exactly one cycle; beat counter <= 0; -> FEED.
REQ-020 FEED: o_ready=1; accept = i_valid & o_ready.
REQ-021 On accept, next cycle o_A<=i_A, o_B<=i_B, o_push<=1; beat counter increments.
REQ-022 FEED cycle with i_valid=0: next cycle o_push<=0, o_A<=0, o_B<=0 (bubble, counter unchanged).
REQ-023 Accept of beat N-1 (counter==N-1): -> DRAIN, drain counter <= 0; o_ready=0 from next cycle.
REQ-024 DRAIN: o_ready=0, o_push=0, o_A=o_B=0; counter increments each cycle; at DRAIN_CYC-1 -> DONE.
REQ-025 DONE: o_done=1 for one cycle; -> IDLE.
REQ-026 Tile latency: exactly DRAIN_CYC+1 cycles from last o_push high to o_done high.
REQ-027 i_start SHALL be ignored outside IDLE; no queuing of a second start.
REQ-028 i_start in the DONE cycle is ignored; a start in the following IDLE cycle is honored.
REQ-029 i_valid in IDLE, CLEAR, DRAIN, DONE SHALL be ignored (no accept, no counter change).
REQ-030 Counters SHALL be sized ceil(log2(max(N,DRAIN_CYC)+1)) bits; no wrap during a tile.
REQ-031 o_busy = (state != IDLE), combinational from state register.

Reset
REQ-032 Asserting i_rst_n=0 at any time, including mid-FEED or mid-DRAIN, SHALL immediately force state=IDLE, counters=0.
REQ-033 Reset values: o_A=0, o_B=0, o_push=0, o_pe_clr=0, o_done=0, o_ready=0, o_busy=0.
REQ-034 After deassertion, first accepted i_start SHALL run a complete tile with no residue from the aborted one.

Verification
REQ-035 Nominal: start; beats A=0x111/B=0x222, 0x333/0x444, 0x555/0x666 back-to-back -> o_pe_clr one cycle, o_push high 3 consecutive cycles with those values, o_done 8 cycles after last o_push.
REQ-036 Bubbles: i_valid pattern 1,0,1,0,1 in FEED -> o_push 1,0,1,0,1; zeros on bubble cycles; exactly 3 beats counted; o_done timing relative to last push unchanged.
REQ-037 Ignored inputs: i_valid=1 with 0xAAA/0xBBB in IDLE and DRAIN, i_start pulsed in FEED/DRAIN/DONE -> no o_push, no extra tile, single o_done.
REQ-038 Reset mid-operation: i_rst_n=0 after second beat accepted -> all outputs 0 asynchronously; new start then produces full 3-beat tile and one o_done.
REQ-039 Back-to-back tiles: i_start asserted the cycle after o_done -> second CLEAR/FEED/DRAIN sequence identical in timing to the first.
REQ-040 Parameter sweep N=4, DW=8: 4 beats of 32-bit rows -> o_done 11 cycles after last o_push (DRAIN_CYC=10).
